// File: rtl/pc_unit_if.sv
// pc_unit_if: next-PC select, redirect controls and PC/EPC/status outputs
// shared between the PC stage and its upstream/downstream neighbours.
interface pc_unit_if;
    logic        stall;
    logic [1:0]  pcsource;
    logic [31:0] pcplus4;
    logic [31:0] bpc;
    logic [31:0] rpc;
    logic [31:0] jpc;
    logic        trap;
    logic        eret;
    logic        halt;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        running;
    logic [31:0] icount;
    logic        fault;

    // Driver side: fetch/decode/control feeding the PC stage
    modport master (
        output stall, pcsource, pcplus4, bpc, rpc, jpc, trap, eret, halt,
        input  pc, epc, running, icount, fault
    );

    // PC stage side
    modport slave (
        input  stall, pcsource, pcplus4, bpc, rpc, jpc, trap, eret, halt,
        output pc, epc, running, icount, fault
    );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: program-counter stage. Holds PC/EPC, selects the next PC from
// fetch/decode targets, handles stall, trap/eret redirection, halt and an
// advance counter.
// Optional feature macro: PC_ALIGN_CHECK_EN -- when defined, a misaligned
// advance target redirects to TRAP_VEC and pulses fault; when undefined the
// target's low two bits are cleared before loading pc.
module pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] TRAP_VEC = 32'h00000008
) (
    input  logic       clk,
    input  logic       resetn,
    pc_unit_if.slave   bus
);
    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_epc;
    logic [31:0] r_icount;
    logic        r_running;
    logic        r_fault;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_epc_nxt;
    logic [31:0] w_icount_nxt;
    logic        w_fault_nxt;
    logic [31:0] w_sel;
    logic [31:0] w_dest;
    logic        w_adv;

    // Next-PC source multiplexer
    always_comb begin
        w_sel = bus.pcplus4;
        case (bus.pcsource)
            2'b00:   w_sel = bus.pcplus4;
            2'b01:   w_sel = bus.bpc;
            2'b10:   w_sel = bus.rpc;
            default: w_sel = bus.jpc;
        endcase
    end

    // Next-state and next-register computation (priority: trap, eret, halt, stall)
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_epc_nxt    = r_epc;
        w_icount_nxt = r_icount;
        w_fault_nxt  = 1'b0;
        w_adv        = 1'b0;
        w_dest       = r_pc;

        case (r_state)
            S_BOOT: begin
                w_pc_nxt    = RESET_PC;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (bus.trap) begin
                    w_epc_nxt    = r_pc;
                    w_pc_nxt     = TRAP_VEC;
                    w_icount_nxt = r_icount + 32'd1;
                end else if (bus.eret) begin
                    w_adv  = 1'b1;
                    w_dest = r_epc;
                end else if (bus.halt) begin
                    w_state_nxt = S_HALT;
                end else if (!bus.stall) begin
                    w_adv  = 1'b1;
                    w_dest = w_sel;
                end
            end
            default: begin
                w_state_nxt = S_HALT;
            end
        endcase

        if (w_adv) begin
            w_icount_nxt = r_icount + 32'd1;
`ifdef PC_ALIGN_CHECK_EN
            if (w_dest[1:0] != 2'b00) begin
                w_pc_nxt    = TRAP_VEC;
                w_epc_nxt   = r_pc;
                w_fault_nxt = 1'b1;
            end else begin
                w_pc_nxt = w_dest;
            end
`else
            w_pc_nxt = {w_dest[31:2], 2'b00};
`endif
        end
    end

    // State, PC, EPC, counter and status registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_BOOT;
            r_pc      <= RESET_PC;
            r_epc     <= 32'h00000000;
            r_icount  <= 32'h00000000;
            r_running <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_epc     <= w_epc_nxt;
            r_icount  <= w_icount_nxt;
            r_running <= (w_state_nxt == S_RUN);
            r_fault   <= w_fault_nxt;
        end
    end

    assign bus.pc      = r_pc;
    assign bus.epc     = r_epc;
    assign bus.icount  = r_icount;
    assign bus.running = r_running;
    assign bus.fault   = r_fault;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed self-checking bench for pc_unit.
module tb_pc_unit;
    logic clk;
    logic resetn;
    int   n_checks;
    int   n_fail;

    pc_unit_if bus ();

    pc_unit #(
        .RESET_PC (32'h00000000),
        .TRAP_VEC (32'h00000008)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_epc,
                           input logic [31:0] e_ic, input logic e_run, input logic e_fault);
        chk({tag, ".pc"},      bus.pc,             e_pc);
        chk({tag, ".epc"},     bus.epc,            e_epc);
        chk({tag, ".icount"},  bus.icount,         e_ic);
        chk({tag, ".running"}, {31'd0, bus.running}, {31'd0, e_run});
        chk({tag, ".fault"},   {31'd0, bus.fault},   {31'd0, e_fault});
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        resetn       = 1'b0;
        bus.stall    = 1'b0;
        bus.pcsource = 2'b00;
        bus.pcplus4  = 32'h4;
        bus.bpc      = 32'h0;
        bus.rpc      = 32'h0;
        bus.jpc      = 32'h0;
        bus.trap     = 1'b0;
        bus.eret     = 1'b0;
        bus.halt     = 1'b0;

        // Reset state
        tick();
        tick();
        chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Release; first edge is BOOT -> RUN with pc still RESET_PC
        resetn = 1'b1;
        bus.trap = 1'b1;
        tick();
        bus.trap = 1'b0;
        chk_all("boot", 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Sequential advance via pcplus4
        tick();
        chk_all("seq1", 32'h4, 32'h0, 32'd1, 1'b1, 1'b0);
        bus.pcplus4 = 32'h8;
        tick();
        chk_all("seq2", 32'h8, 32'h0, 32'd2, 1'b1, 1'b0);
        bus.pcplus4 = 32'hC;
        tick();
        chk_all("seq3", 32'hC, 32'h0, 32'd3, 1'b1, 1'b0);
        bus.pcplus4 = 32'h10;
        tick();
        chk_all("seq4", 32'h10, 32'h0, 32'd4, 1'b1, 1'b0);

        // Stall holds pc and icount for three cycles
        bus.stall    = 1'b1;
        bus.pcsource = 2'b11;
        bus.jpc      = 32'h40;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall.pc", bus.pc, 32'h10);
            chk("stall.icount", bus.icount, 32'd4);
        end
        bus.stall = 1'b0;
        tick();
        chk_all("jump", 32'h40, 32'h0, 32'd5, 1'b1, 1'b0);

        // Branch select
        bus.pcsource = 2'b01;
        bus.bpc      = 32'h20;
        tick();
        chk_all("branch", 32'h20, 32'h0, 32'd6, 1'b1, 1'b0);

        // Trap beats stall and halt
        bus.trap  = 1'b1;
        bus.stall = 1'b1;
        bus.halt  = 1'b1;
        tick();
        chk_all("trap", 32'h8, 32'h20, 32'd7, 1'b1, 1'b0);
        bus.trap  = 1'b0;
        bus.stall = 1'b0;
        bus.halt  = 1'b0;

        // Eret beats stall and halt; epc untouched
        bus.eret  = 1'b1;
        bus.stall = 1'b1;
        bus.halt  = 1'b1;
        tick();
        chk_all("eret", 32'h20, 32'h20, 32'd8, 1'b1, 1'b0);
        bus.eret  = 1'b0;
        bus.stall = 1'b0;
        bus.halt  = 1'b0;

        // Misaligned register target
        bus.pcsource = 2'b10;
        bus.rpc      = 32'h00000046;
        tick();
`ifdef PC_ALIGN_CHECK_EN
        chk_all("misalign", 32'h8, 32'h20, 32'd9, 1'b1, 1'b1);
`else
        chk_all("misalign", 32'h44, 32'h20, 32'd9, 1'b1, 1'b0);
`endif
        bus.pcsource = 2'b11;
        bus.jpc      = 32'h30;
        tick();
        chk_all("postalign", 32'h30, 32'h20, 32'd10, 1'b1, 1'b0);

        // icount wrap: preload all-ones while stalled, then advance once
        bus.stall = 1'b1;
        force dut.r_icount = 32'hFFFFFFFF;
        #1;
        release dut.r_icount;
        tick();
        chk("wrap.pre", bus.icount, 32'hFFFFFFFF);
        bus.stall = 1'b0;
        tick();
        chk("wrap.icount", bus.icount, 32'h0);
        chk("wrap.pc", bus.pc, 32'h30);

        // Halt freezes everything, inputs ignored afterwards
        bus.halt = 1'b1;
        tick();
        chk_all("halt", 32'h30, 32'h20, 32'h0, 1'b0, 1'b0);
        bus.halt     = 1'b0;
        bus.trap     = 1'b1;
        bus.pcsource = 2'b11;
        bus.jpc      = 32'h80;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("halted.pc", bus.pc, 32'h30);
            chk("halted.running", {31'd0, bus.running}, 32'd0);
        end
        chk("halted.icount", bus.icount, 32'h0);
        chk("halted.epc", bus.epc, 32'h20);

        // Asynchronous reset mid-cycle
        #2;
        resetn = 1'b0;
        #1;
        chk_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        bus.trap = 1'b0;
        resetn   = 1'b1;
        tick();
        chk_all("reboot", 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
